// File: rtl/cont_gate_ctrl_if.sv
// rtl/cont_gate_ctrl_if.sv - control/readout signal bundle between the gate sequencer and the counter/display side
interface cont_gate_ctrl_if;
   logic       run;
   logic       single;
   logic [3:0] cont_3;
   logic [3:0] cont_2;
   logic [3:0] cont_1;
   logic [3:0] cont_0;
   logic       hab;
   logic       limp;
   logic [3:0] res_3;
   logic [3:0] res_2;
   logic [3:0] res_1;
   logic [3:0] res_0;
   logic       res_valid;
   logic       busy;
   logic       ovf;

   // Sequencer side: takes requests and counter digits, drives counter control and the result
   modport master (
      input  run, single, cont_3, cont_2, cont_1, cont_0,
      output hab, limp, res_3, res_2, res_1, res_0, res_valid, busy, ovf
   );

   // Environment side: issues requests, supplies digits, consumes the result
   modport slave (
      output run, single, cont_3, cont_2, cont_1, cont_0,
      input  hab, limp, res_3, res_2, res_1, res_0, res_valid, busy, ovf
   );
endinterface

// File: rtl/cont_gate_ctrl.sv
// rtl/cont_gate_ctrl.sv - clear/gate/settle/latch sequencer turning the BCD event counter into periodic measurements
// Optional feature macro: OVERFLOW_DETECT_EN (thousands-digit wrap during the gate saturates the result to 9999 and sets ovf)
module cont_gate_ctrl #(
   parameter int GATE_CYCLES   = 1000,
   parameter int CLEAR_CYCLES  = 2,
   parameter int SETTLE_CYCLES = 2
) (
   input  logic             clk,
   input  logic             RESET,
   cont_gate_ctrl_if.master ctl_if
);

   localparam int MAX_AB  = (GATE_CYCLES > CLEAR_CYCLES) ? GATE_CYCLES : CLEAR_CYCLES;
   localparam int MAX_CYC = (MAX_AB > SETTLE_CYCLES) ? MAX_AB : SETTLE_CYCLES;
   localparam int CNT_W   = $clog2(MAX_CYC + 1);

   // Dwell counter counts down to zero; loaded with length-1 on state entry
   localparam logic [CNT_W-1:0] CLEAR_LOAD  = CNT_W'(CLEAR_CYCLES - 1);
   localparam logic [CNT_W-1:0] GATE_LOAD   = CNT_W'(GATE_CYCLES - 1);
   localparam logic [CNT_W-1:0] SETTLE_LOAD = CNT_W'(SETTLE_CYCLES - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_CLEAR,
      S_GATE,
      S_SETTLE,
      S_LATCH
   } state_t;

   state_t           state_q;
   logic [CNT_W-1:0] cnt_q;
   logic             hab_q;
   logic             limp_q;
   logic [15:0]      res_q;
   logic             res_valid_q;
   logic             busy_q;
   logic [15:0]      cont_w;
   logic             start_d;

`ifdef OVERFLOW_DETECT_EN
   logic             ovf_q;
   logic             flag_q;
   logic [3:0]       prev3_q;
`endif

   assign cont_w = {ctl_if.cont_3, ctl_if.cont_2, ctl_if.cont_1, ctl_if.cont_0};

   // A new measurement starts from IDLE on any request, or straight after LATCH while run stays high
   assign start_d = ((state_q == S_IDLE)  && (ctl_if.run || ctl_if.single)) ||
                    ((state_q == S_LATCH) &&  ctl_if.run);

   // Sequencer: state, dwell counter and all registered outputs, set on entry to each state
   always_ff @(posedge clk) begin
      if (RESET) begin
         state_q     <= S_IDLE;
         cnt_q       <= '0;
         hab_q       <= 1'b0;
         limp_q      <= 1'b0;
         res_q       <= '0;
         res_valid_q <= 1'b0;
         busy_q      <= 1'b0;
`ifdef OVERFLOW_DETECT_EN
         ovf_q       <= 1'b0;
         flag_q      <= 1'b0;
         prev3_q     <= '0;
`endif
      end else begin
         res_valid_q <= 1'b0;
`ifdef OVERFLOW_DETECT_EN
         // Track the thousands digit from the clear phase on, so the first gate cycle has a valid predecessor
         if (state_q == S_CLEAR || state_q == S_GATE)
            prev3_q <= ctl_if.cont_3;
         if (state_q == S_GATE && prev3_q == 4'd9 && ctl_if.cont_3 == 4'd0)
            flag_q <= 1'b1;
`endif
         case (state_q)
            S_IDLE: begin
            end
            S_CLEAR: begin
               if (cnt_q == '0) begin
                  state_q <= S_GATE;
                  cnt_q   <= GATE_LOAD;
                  limp_q  <= 1'b0;
                  hab_q   <= 1'b1;
               end else begin
                  cnt_q <= cnt_q - 1'b1;
               end
            end
            S_GATE: begin
               if (cnt_q == '0) begin
                  state_q <= S_SETTLE;
                  cnt_q   <= SETTLE_LOAD;
                  hab_q   <= 1'b0;
               end else begin
                  cnt_q <= cnt_q - 1'b1;
               end
            end
            S_SETTLE: begin
               if (cnt_q == '0) begin
                  state_q     <= S_LATCH;
                  cnt_q       <= '0;
                  res_valid_q <= 1'b1;
`ifdef OVERFLOW_DETECT_EN
                  res_q       <= flag_q ? 16'h9999 : cont_w;
                  ovf_q       <= flag_q;
`else
                  res_q       <= cont_w;
`endif
               end else begin
                  cnt_q <= cnt_q - 1'b1;
               end
            end
            S_LATCH: begin
               if (!ctl_if.run) begin
                  state_q <= S_IDLE;
                  cnt_q   <= '0;
                  busy_q  <= 1'b0;
               end
            end
            default: begin
               state_q <= S_IDLE;
               cnt_q   <= '0;
               hab_q   <= 1'b0;
               limp_q  <= 1'b0;
               busy_q  <= 1'b0;
            end
         endcase
         if (start_d) begin
            state_q <= S_CLEAR;
            cnt_q   <= CLEAR_LOAD;
            limp_q  <= 1'b1;
            hab_q   <= 1'b0;
            busy_q  <= 1'b1;
`ifdef OVERFLOW_DETECT_EN
            flag_q  <= 1'b0;
`endif
         end
      end
   end

   assign ctl_if.hab       = hab_q;
   assign ctl_if.limp      = limp_q;
   assign ctl_if.res_3     = res_q[15:12];
   assign ctl_if.res_2     = res_q[11:8];
   assign ctl_if.res_1     = res_q[7:4];
   assign ctl_if.res_0     = res_q[3:0];
   assign ctl_if.res_valid = res_valid_q;
   assign ctl_if.busy      = busy_q;
`ifdef OVERFLOW_DETECT_EN
   assign ctl_if.ovf       = ovf_q;
`else
   assign ctl_if.ovf       = 1'b0;
`endif

endmodule

// File: tb/tb_cont_gate_ctrl.sv
// tb/tb_cont_gate_ctrl.sv - scoreboard bench for cont_gate_ctrl with a behavioural BCD counter and measurement model
module tb_cont_gate_ctrl;
   localparam int G = 10;
   localparam int C = 2;
   localparam int S = 2;
   localparam int P = C + G + S + 1;

   typedef struct {
      logic [15:0] res;
      logic        ovf;
      int          due;
   } exp_t;

   logic clk = 1'b0;
   logic RESET;
   always #5 clk = ~clk;

   cont_gate_ctrl_if ctl_if();

   cont_gate_ctrl #(
      .GATE_CYCLES  (G),
      .CLEAR_CYCLES (C),
      .SETTLE_CYCLES(S)
   ) dut (
      .clk   (clk),
      .RESET (RESET),
      .ctl_if(ctl_if)
   );

   int n_checks = 0;
   int n_fail   = 0;

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp, input int at);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s at edge %0d: got %0h, expected %0h", nm, at, act, exp);
      end
   endtask

   function automatic logic [15:0] to_bcd(input int v);
      to_bcd = {4'((v / 1000) % 10), 4'((v / 100) % 10), 4'((v / 10) % 10), 4'(v % 10)};
   endfunction

   // Counter environment: decimal event counter, cleared to 'preset' by limp, counts while hab
   int          env_cnt  = 0;
   int          preset   = 0;
   logic        raw_mode = 1'b0;
   logic [15:0] raw_val  = 16'h0;
   logic [15:0] cont_v;

   always @(posedge clk) begin
      if (ctl_if.limp)     env_cnt <= preset;
      else if (ctl_if.hab) env_cnt <= (env_cnt + 1) % 10000;
   end

   assign cont_v        = raw_mode ? raw_val : to_bcd(env_cnt);
   assign ctl_if.cont_3 = cont_v[15:12];
   assign ctl_if.cont_2 = cont_v[11:8];
   assign ctl_if.cont_1 = cont_v[7:4];
   assign ctl_if.cont_0 = cont_v[3:0];

   // Reference model: one measurement = P edges from the accepted request; result = preset + G counts
   exp_t        sb[$];
   int          edge_n   = 0;
   bit          m_active = 1'b0;
   int          m_start  = 0;
   logic [15:0] m_res    = 16'h0;
   logic        m_ovf    = 1'b0;
   logic [15:0] m_next_res;
   logic        m_next_ovf;

   always @(posedge clk) begin
      edge_n++;
      if (RESET) begin
         m_active = 1'b0;
         sb.delete();
         m_res = 16'h0;
         m_ovf = 1'b0;
      end else begin
         if (m_active && edge_n == m_start + P - 1) begin
            m_res = m_next_res;
            m_ovf = m_next_ovf;
         end
         if ((!m_active && (ctl_if.run || ctl_if.single)) ||
             (m_active && edge_n == m_start + P && ctl_if.run)) begin
            exp_t e;
            m_active = 1'b1;
            m_start  = edge_n;
            if (raw_mode) begin
               m_next_res = raw_val;
               m_next_ovf = 1'b0;
            end else begin
               m_next_res = to_bcd((preset + G) % 10000);
`ifdef OVERFLOW_DETECT_EN
               // Wrap is seen while the gate is open: counts preset..preset+G-1 are observed in GATE
               m_next_ovf = (preset + G - 1) >= 10000;
               if (m_next_ovf) m_next_res = 16'h9999;
`else
               m_next_ovf = 1'b0;
`endif
            end
            e.res = m_next_res;
            e.ovf = m_next_ovf;
            e.due = edge_n + P - 1;
            sb.push_back(e);
         end else if (m_active && edge_n == m_start + P) begin
            m_active = 1'b0;
         end
      end
   end

   // Monitor: per-cycle control checks plus scoreboard pop on every res_valid
   always @(negedge clk) begin
      if (edge_n > 0) begin
         int   p;
         logic e_limp, e_hab, e_rv;
         p      = edge_n - m_start;
         e_limp = m_active && p < C;
         e_hab  = m_active && p >= C && p < C + G;
         e_rv   = m_active && p == P - 1;
         check("limp", 32'(ctl_if.limp), 32'(e_limp), edge_n);
         check("hab", 32'(ctl_if.hab), 32'(e_hab), edge_n);
         check("busy", 32'(ctl_if.busy), 32'(m_active), edge_n);
         check("res_valid", 32'(ctl_if.res_valid), 32'(e_rv), edge_n);
         check("hab_limp_excl", 32'(ctl_if.hab & ctl_if.limp), 32'd0, edge_n);
         check("res_hold", 32'({ctl_if.res_3, ctl_if.res_2, ctl_if.res_1, ctl_if.res_0}), 32'(m_res), edge_n);
         check("ovf_hold", 32'(ctl_if.ovf), 32'(m_ovf), edge_n);
         if (ctl_if.res_valid) begin
            if (sb.size() == 0) begin
               check("unexpected_res_valid", 32'd1, 32'd0, edge_n);
            end else begin
               exp_t e;
               e = sb.pop_front();
               check("sb_res", 32'({ctl_if.res_3, ctl_if.res_2, ctl_if.res_1, ctl_if.res_0}), 32'(e.res), edge_n);
               check("sb_ovf", 32'(ctl_if.ovf), 32'(e.ovf), edge_n);
               check("sb_time", 32'(edge_n), 32'(e.due), edge_n);
            end
         end else if (sb.size() > 0 && sb[0].due < edge_n) begin
            exp_t e;
            e = sb.pop_front();
            check("missing_res_valid", 32'(edge_n), 32'(e.due), edge_n);
         end
      end
   end

   task automatic cycles(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic pulse_single();
      ctl_if.single = 1'b1;
      cycles(1);
      ctl_if.single = 1'b0;
   endtask

   initial begin
      RESET = 1'b1;
      ctl_if.run = 1'b0;
      ctl_if.single = 1'b0;
      cycles(3);
      RESET = 1'b0;
      cycles(2);

      // Single measurement from a cleared counter
      pulse_single();
      cycles(P + 4);

      // Continuous mode, then run dropped in the middle of a gate
      ctl_if.run = 1'b1;
      cycles(3 * P + 6);
      ctl_if.run = 1'b0;
      cycles(2 * P);

      // Extra single pulses during GATE and SETTLE are ignored
      pulse_single();
      cycles(5);
      pulse_single();
      cycles(7);
      pulse_single();
      cycles(P);

      // Reset in the middle of a gate aborts without a result
      pulse_single();
      cycles(6);
      RESET = 1'b1;
      cycles(1);
      RESET = 1'b0;
      cycles(P + 4);

      // Counter wraps during the gate
      preset = 9995;
      pulse_single();
      cycles(P + 4);
      preset = 0;

      // Non-BCD digits pass through unchanged
      raw_mode = 1'b1;
      raw_val  = 16'hABCD;
      pulse_single();
      cycles(P + 4);
      raw_mode = 1'b0;

      // Randomized requests, presets and occasional resets
      for (int i = 0; i < 1500; i++) begin
         if (RESET) RESET = 1'b0;
         else if ($urandom_range(0, 199) == 0) RESET = 1'b1;
         if (!m_active && !ctl_if.run) begin
            int sel;
            sel = $urandom_range(0, 3);
            raw_mode = (sel == 0);
            raw_val  = 16'($urandom);
            preset   = (sel == 1) ? 9990 + $urandom_range(0, 9) : (sel == 2) ? $urandom_range(0, 9989) : 0;
         end
         if (!m_active || ctl_if.run) begin
            if ($urandom_range(0, 29) == 0) ctl_if.run = ~ctl_if.run;
         end else if ($urandom_range(0, 9) == 0) begin
            ctl_if.run = 1'b0;
         end
         ctl_if.single = ($urandom_range(0, 7) == 0);
         cycles(1);
      end
      RESET = 1'b0;
      ctl_if.run = 1'b0;
      ctl_if.single = 1'b0;
      cycles(2 * P);
      check("scoreboard_drained", 32'(sb.size()), 32'd0, edge_n);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule

// File: doc/cont_gate_ctrl.md
# cont_gate_ctrl

Measurement sequencer for the 4-digit BCD event counter: drives its `hab` (count enable) and `limp` (clear) inputs, reads the four BCD digits back after each gate window, and presents a latched result to the display/readout logic. It is the control and readout end of the counter interface, clocked by the same sample clock, and turns the free-running counter into a periodic frequency/event measurement.

## Interface
- GATE_CYCLES, 1000, number of clk cycles `hab` is held high per measurement (≥1)
- CLEAR_CYCLES, 2, number of clk cycles `limp` is held high before each gate (≥1)
- SETTLE_CYCLES, 2, idle cycles between `hab` falling and digit capture (≥1)

- clk  in  1  sample clock, shared with the counter; all logic on rising edge
- RESET  in  1  reset RESET, synchronous, active-high
- run  in  1  continuous mode: start a new measurement after each result while high
- single  in  1  one-shot request, sampled in IDLE only
- cont_3..cont_0  in  4 each  BCD digits from the counter (thousands..units)
- hab  out  1  counter enable
- limp  out  1  counter clear
- res_3..res_0  out  4 each  latched result digits
- res_valid  out  1  one-cycle pulse, result updated this cycle
- busy  out  1  high in every state except IDLE
- ovf  out  1  overflow flag for the latched result (see Configuration)

## Operation
- All outputs registered. Reset values: hab=0, limp=0, res_*=0, res_valid=0, busy=0, ovf=0; state IDLE, cycle counter 0.
- States: IDLE, CLEAR, GATE, SETTLE, LATCH.
- IDLE: hab=0, limp=0. run=1 or single=1 → CLEAR.
- CLEAR: limp=1 for exactly CLEAR_CYCLES, then → GATE.
- GATE: hab=1, limp=0 for exactly GATE_CYCLES, then → SETTLE.
- SETTLE: hab=0, limp=0 for SETTLE_CYCLES, then → LATCH.
- LATCH: one cycle; res_3..res_0 ← cont_3..cont_0; res_valid=1; → CLEAR if run=1, else → IDLE.
- single outside IDLE is ignored (not queued). run falling mid-measurement: current measurement completes and produces its result, then IDLE.
- Digits are copied unchanged; no BCD validity check (values >9 pass through).
- res_* hold their value until the next LATCH or RESET.
- RESET mid-operation: abort at the next edge; all outputs to reset values, no res_valid for the aborted measurement.
- hab and limp are never high in the same cycle.

## Timing
- Request sampled high at edge k (IDLE): limp high cycles k+1..k+CLEAR_CYCLES; hab high k+CLEAR_CYCLES+1..k+CLEAR_CYCLES+GATE_CYCLES; res_valid at k+CLEAR_CYCLES+GATE_CYCLES+SETTLE_CYCLES+1.
- busy rises at k+1, falls the cycle after LATCH when returning to IDLE.
- Continuous mode period: CLEAR_CYCLES+GATE_CYCLES+SETTLE_CYCLES+1 cycles; limp reasserts the cycle after res_valid.
- Cycle counter width: ceil(log2(max parameter+1)); reloaded on every state entry, no wrap.

## Configuration
- OVERFLOW_DETECT_EN defined: during GATE, previous cont_3 registered; transition 9→0 sets a sticky internal flag (cleared on CLEAR entry). At LATCH, if flag set: res_* forced to 9,9,9,9 and ovf=1; otherwise ovf=0. ovf updated only at LATCH/RESET.
- Not defined: no detection logic, ovf tied to 0, res_* always raw digits.

## Test plan
- GATE=10, CLEAR=2, SETTLE=2, counter model increments per clk while hab; single pulse at k → limp k+1..k+2, hab k+3..k+12, res_valid at k+15, res=0,0,1,0, busy low at k+16.
- run held high → res_valid every 15 cycles, each result 0010, limp high the cycle after every res_valid, hab/limp never overlap.
- RESET asserted during GATE → next cycle hab=0, limp=0, busy=0, res=0000; no res_valid follows.
- single pulsed again during GATE and SETTLE → exactly one res_valid, then IDLE.
- Counter preset 9995, GATE=10: with OVERFLOW_DETECT_EN res=9999, ovf=1; without res=0005, ovf=0.
- run dropped mid-GATE → measurement completes, one res_valid with correct count, then IDLE, busy=0.
